gray_code_counter: RTL and testbench
====================================

# gray_code_counter

Parameterised up/down Gray-code sequence source with a valid/ready output handshake. It keeps an internal binary count and presents the Gray-encoded value of that count on `gray_out`, advancing one step per accepted word. It is the encode-side counterpart of the Gray-to-binary converter. It drives Gray-coded stimulus and pointer words into downstream decode logic, and supports backpressure, parallel load, and wrap signalling.

## Interface
- `WIDTH`, default 4: width in bits of the count, `gray_out` and `load_value`; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; starts and continues word generation.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled on each accept.
- `load`  in  1  synchronous parallel load of the count; highest priority.
- `load_value`  in  WIDTH  binary value to load.
- `out_ready`  in  1  sink ready.
- `out_valid`  out  1  `gray_out` holds a word offered to the sink.
- `gray_out`  out  WIDTH  registered Gray code of `bin_count`: `bin_count ^ (bin_count >> 1)`.
- `bin_count`  out  WIDTH  registered internal binary count; for debug and checking.
- `wrap`  out  1  one-cycle pulse: the count has just wrapped.

## Operation
- **Reset** (rst = 0, asynchronous): state IDLE; `bin_count` = 0, `gray_out` = 0, `out_valid` = 0, `wrap` = 0. These are held while rst is low.
- **FSM states**: IDLE (`out_valid` = 0) and RUN (`out_valid` = 1).
- **IDLE**:
  - en = 1 and load = 0 → RUN. The current count is offered unchanged; there is no advance.
  - Otherwise stay in IDLE.
- **RUN**: an *accept* is a cycle with `out_valid` & `out_ready`.
  - On accept, the count advances by +1 if up = 1, or by −1 if up = 0, modulo 2^WIDTH.
  - After an accept, the next state is RUN if en = 1, else IDLE.
  - No accept: `gray_out`, `bin_count` and `out_valid` are held stable, whatever the values of en and up.
- **Load** has priority over everything except reset, in either state:
  - `bin_count` ← `load_value` and `gray_out` ← Gray(`load_value`); next state IDLE; `wrap` = 0.
  - If load coincides with an accept, the word on `gray_out` that cycle counts as delivered, but the advance is discarded.
- **Wrap**: `wrap` = 1 for exactly one cycle after an accept that moves the count from 2^WIDTH−1 to 0 (up) or from 0 to 2^WIDTH−1 (down). Otherwise `wrap` = 0.
- **Gray invariant**: `gray_out` always equals Gray(`bin_count`). Consecutive offered words differ in exactly one bit, including across a wrap.
- **Arithmetic**: the count is plain unsigned WIDTH-bit, and the carry/borrow is dropped.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- en sampled high in IDLE → `out_valid` = 1 at the next rising edge.
- Throughput is one word per cycle while en = 1 and `out_ready` = 1.
- `gray_out` updates on the edge that ends an accept cycle.
- `wrap` asserts on that same edge, alongside the new word.
- `out_valid` never drops without an accept, except on load or reset.
- Reset asserted mid-run forces the reset values immediately, with no clock required. On release, the block restarts from IDLE.
- rst deassertion is assumed synchronised externally to `clk`.

## Test plan
- **Reset.** Assert rst = 0 mid-run with `gray_out` = 0110. Required: `gray_out` = 0000, `bin_count` = 0, and `out_valid` = 0 immediately. After release with en = 1, the first word is 0000 one cycle later.
- **Up count.** WIDTH = 4, en = 1, up = 1, `out_ready` = 1. Required: `gray_out` sequence 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, …, 1000, 0000. `wrap` pulses once, alongside 0000, and every step changes exactly 1 bit.
- **Backpressure.** During the up count at `gray_out` = 0011, drop `out_ready` for 3 cycles and toggle en and up. Required: `gray_out` = 0011 and `out_valid` = 1 are held. After `out_ready` returns, the next word is 0010, provided up = 1 at the accept.
- **Down count.** Load 0, set en = 1 and up = 0. Required: words 0000, then 1000 (binary 15) with a `wrap` pulse, then 1001 (binary 14).
- **Load.** Assert load with `load_value` = 5 while running and accepting. Required: the next cycle shows `out_valid` = 0, `bin_count` = 5, `gray_out` = 0111, `wrap` = 0. Then 0111 is offered one cycle after en is seen, followed by 0101.
- **Stop.** Deassert en while running with `out_ready` = 1. Required: the word accepted in the en = 0 cycle is the last one, and `out_valid` = 0 on the next edge with the count advanced by one.

Source files
------------

// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down Gray-code word source with a valid/ready output.
// An internal binary count is kept; its Gray encoding is presented on
// gray_out. The count advances by one step per accepted word, can be
// parallel-loaded at any time, and signals wrap-around with a one-cycle pulse.
// Every output comes straight from a register.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_count,
  output logic             wrap
);

  // IDLE offers nothing. RUN offers the current word to the sink.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] gray_reg, gray_next;
  logic             wrap_reg, wrap_next;
  logic             accept;

  // A word is delivered only while it is offered and the sink takes it.
  assign accept = (state_reg == RUN) && out_ready;

  // Next-state, next-count and wrap decision. Load overrides all of them.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      // A word accepted in this same cycle still counts as delivered,
      // but its advance is discarded in favour of the loaded value.
      count_next = load_value;
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          // Start offering the current count unchanged. No advance here.
          if (en) begin
            state_next = RUN;
          end
        end
        RUN: begin
          // Without an accept, everything holds, whatever en and up are.
          if (accept) begin
            if (up) begin
              count_next = count_reg + COUNT_ONE;
              wrap_next  = (count_reg == COUNT_MAX);
            end else begin
              count_next = count_reg - COUNT_ONE;
              wrap_next  = (count_reg == '0);
            end
            state_next = en ? RUN : IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Gray encode the next count so gray_out is registered together with
  // bin_count. Each bit is the XOR of a bit and its upper neighbour, and the
  // MSB passes straight through.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray_bit
      assign gray_next[gi] = count_next[gi] ^ count_next[gi+1];
    end
  endgenerate
  assign gray_next[WIDTH-1] = count_next[WIDTH-1];

  // State, count, Gray word and wrap pulse registers. The async reset forces
  // the idle/zero state at once, with no clock needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      gray_reg  <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      gray_reg  <= gray_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign out_valid = (state_reg == RUN);
  assign gray_out  = gray_reg;
  assign bin_count = count_reg;
  assign wrap      = wrap_reg;

endmodule

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed scenarios with literal expectations, then
// randomized stimulus. A behavioural model tracks the integer count and the
// offered/idle condition. A negedge compare process checks every DUT output
// against that model on every cycle.
module tb_gray_code_counter;
  localparam int WIDTH = 4;
  localparam int M = 1 << WIDTH;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_count;
  logic             wrap;

  int n_checks = 0;
  int n_fail = 0;

  // Behavioural model state
  int m_count = 0;
  bit m_valid = 0;
  bit m_wrap = 0;

  gray_code_counter #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .up(up),
    .load(load),
    .load_value(load_value),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .gray_out(gray_out),
    .bin_count(bin_count),
    .wrap(wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int gray_of(input int v);
    return v ^ (v >> 1);
  endfunction

  // Model: plain modular arithmetic on an integer count
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0;
      m_valid = 0;
      m_wrap = 0;
    end else if (load) begin
      m_count = int'(load_value);
      m_valid = 0;
      m_wrap = 0;
    end else if (!m_valid) begin
      m_wrap = 0;
      if (en) m_valid = 1;
    end else if (out_ready) begin
      if (up) begin
        m_wrap = (m_count == M - 1);
        m_count = (m_count + 1) % M;
      end else begin
        m_wrap = (m_count == 0);
        m_count = (m_count + M - 1) % M;
      end
      m_valid = en;
    end else begin
      m_wrap = 0;
    end
  end

  // Compare process: every cycle, DUT outputs against the model, plus a
  // one-bit-step check between the words on either side of an accept
  bit             step_pending = 0;
  logic [WIDTH-1:0] prev_gray;
  always @(negedge clk) begin
    check("out_valid", int'(out_valid), int'(m_valid));
    check("bin_count", int'(bin_count), m_count);
    check("gray_out", int'(gray_out), gray_of(m_count));
    check("wrap", int'(wrap), int'(m_wrap));
    if (step_pending && rst)
      check("one_bit_step", $countones(prev_gray ^ gray_out), 1);
    step_pending = out_valid && out_ready && !load && rst;
    prev_gray = gray_out;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

  initial begin
    rst = 1'b1;
    en = 1'b0;
    up = 1'b1;
    load = 1'b0;
    load_value = '0;
    out_ready = 1'b0;
    #1 rst = 1'b0;
    repeat (2) step();
    check("reset_valid", int'(out_valid), 0);
    check("reset_gray", int'(gray_out), 0);
    check("reset_bin", int'(bin_count), 0);
    check("reset_wrap", int'(wrap), 0);
    $display("reset: valid=%0b gray=%b", out_valid, gray_out);

    // Up count through a full wrap
    rst = 1'b1;
    en = 1'b1;
    up = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check("up_gray", int'(gray_out), seq[k]);
      check("up_wrap", int'(wrap), (k == 16) ? 1 : 0);
      $display("up word %0d: gray=%b wrap=%0b", k, gray_out, wrap);
    end

    // Backpressure at 0011 while en and up toggle
    step();
    step();
    check("bp_start_gray", int'(gray_out), 3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en = ~en;
      up = ~up;
      step();
      check("bp_hold_gray", int'(gray_out), 3);
      check("bp_hold_valid", int'(out_valid), 1);
      $display("backpressure %0d: gray=%b valid=%0b", i, gray_out, out_valid);
    end
    out_ready = 1'b1;
    en = 1'b1;
    up = 1'b1;
    step();
    check("bp_resume_gray", int'(gray_out), 2);
    $display("resume: gray=%b", gray_out);

    // Load 5 while running and accepting
    load = 1'b1;
    load_value = 4'd5;
    step();
    check("load_valid", int'(out_valid), 0);
    check("load_bin", int'(bin_count), 5);
    check("load_gray", int'(gray_out), 7);
    check("load_wrap", int'(wrap), 0);
    load = 1'b0;
    step();
    check("load_offer_gray", int'(gray_out), 7);
    check("load_offer_valid", int'(out_valid), 1);
    step();
    check("load_next_gray", int'(gray_out), 5);
    $display("load: gray=%b bin=%0d", gray_out, bin_count);

    // Stop: the word accepted with en low is the last one
    en = 1'b0;
    step();
    check("stop_valid", int'(out_valid), 0);
    check("stop_bin", int'(bin_count), 7);
    $display("stop: valid=%0b bin=%0d", out_valid, bin_count);

    // Down count from 0 with wrap
    load = 1'b1;
    load_value = 4'd0;
    step();
    load = 1'b0;
    en = 1'b1;
    up = 1'b0;
    step();
    check("down_gray0", int'(gray_out), 0);
    step();
    check("down_gray1", int'(gray_out), 8);
    check("down_wrap1", int'(wrap), 1);
    check("down_bin1", int'(bin_count), 15);
    step();
    check("down_gray2", int'(gray_out), 9);
    check("down_wrap2", int'(wrap), 0);
    $display("down: gray=%b bin=%0d", gray_out, bin_count);

    // Asynchronous reset mid-run with gray_out = 0110
    load = 1'b1;
    load_value = 4'd4;
    step();
    load = 1'b0;
    up = 1'b1;
    step();
    check("pre_rst_gray", int'(gray_out), 6);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_gray", int'(gray_out), 0);
    check("async_rst_bin", int'(bin_count), 0);
    check("async_rst_valid", int'(out_valid), 0);
    $display("async reset: gray=%b valid=%0b", gray_out, out_valid);
    step();
    rst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_valid", int'(out_valid), 1);
    check("post_rst_gray", int'(gray_out), 0);

    // Randomized stimulus
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(99) < 80);
      up = $urandom_range(1);
      out_ready = ($urandom_range(99) < 70);
      load = ($urandom_range(99) < 3);
      load_value = WIDTH'($urandom_range(M - 1));
      rst = ($urandom_range(199) != 0);
      step();
    end
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
